// File: rtl/led_pkg.sv
// Shared types for the LED PWM bank: channel modes and the per-channel config payload.
package led_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_e;

  typedef struct packed {
    led_mode_e        mode;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] duty;
  } led_cfg_t;

  localparam led_cfg_t CFG_RESET = '{mode: LED_OFF, period: '0, duty: '0};

  // Last count value of a period; a zero period behaves as a period of one.
  function automatic logic [CNT_W-1:0] last_count(input logic [CNT_W-1:0] period);
    return (period == '0) ? '0 : period - CNT_W'(1);
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow/active config, period counter, blink state and registered output.
module led_pwm_channel
  import led_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en,
  input  led_cfg_t wr_cfg,
  input  logic     tick,
  input  logic     sync_all,
  output logic     led
);

  led_cfg_t         shadow;
  led_cfg_t         active;
  logic [CNT_W-1:0] cnt;
  logic             blink_q;

  logic boundary_c;
  logic enter_blink_c;
  logic led_c;

  assign boundary_c    = (cnt == last_count(active.period));
  assign enter_blink_c = (shadow.mode == LED_BLINK) && (active.mode != LED_BLINK);

  always_comb begin
    led_c = 1'b0;
    case (active.mode)
      LED_OFF:   led_c = 1'b0;
      LED_ON:    led_c = 1'b1;
      LED_BLINK: led_c = blink_q;
      LED_PWM:   led_c = (cnt < active.duty);
      default:   led_c = 1'b0;
    endcase
  end

  // Shadow captures writes; active only reloads at a period boundary or a sync.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= CFG_RESET;
      active  <= CFG_RESET;
      cnt     <= '0;
      blink_q <= 1'b0;
      led     <= 1'b0;
    end else begin
      if (wr_en) begin
        shadow <= wr_cfg;
      end
      if (sync_all) begin
        cnt    <= '0;
        active <= shadow;
        if (enter_blink_c) begin
          blink_q <= 1'b0;
        end
      end else if (tick) begin
        if (boundary_c) begin
          cnt     <= '0;
          active  <= shadow;
          blink_q <= enter_blink_c ? 1'b0 : ~blink_q;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      led <= led_c;
    end
  end

endmodule

// File: rtl/led_pwm_bank.sv
// Multi-channel LED driver: shared prescaler, config write decode and error flag.
module led_pwm_bank
  import led_pkg::*;
#(
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned CNT_W    = 8,
  parameter  int unsigned PRESCALE = 4,
  localparam int unsigned CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_duty,
  output logic                cfg_err,
  input  logic                sync_all,
  output logic [CHANNELS-1:0] led
);

  logic [PSC_W-1:0]    psc;
  logic                tick_c;
  logic                accept_c;
  logic [CHANNELS-1:0] hit_c;
  logic [CHANNELS-1:0] wr_en_c;
  led_cfg_t            wr_cfg_c;

  assign tick_c   = (psc == PSC_W'(PRESCALE - 1));
  assign accept_c = cfg_valid & cfg_ready;
  assign wr_cfg_c = '{mode: led_mode_e'(cfg_mode), period: cfg_period, duty: cfg_duty};

  // One-hot channel decode; no hit means the write targets a missing channel.
  always_comb begin
    hit_c = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (cfg_chan == CHAN_W'(c)) begin
        hit_c[c] = 1'b1;
      end
    end
    wr_en_c = hit_c & {CHANNELS{accept_c}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc       <= '0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= 1'b1;
      cfg_err   <= accept_c & ~(|hit_c);
      if (sync_all || tick_c) begin
        psc <= '0;
      end else begin
        psc <= psc + PSC_W'(1);
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    led_pwm_channel u_chan (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en_c[g]),
      .wr_cfg   (wr_cfg_c),
      .tick     (tick_c),
      .sync_all (sync_all),
      .led      (led[g])
    );
  end

endmodule

// File: tb/tb_led_pwm_bank.sv
// Scoreboard bench: a 4-channel and a 3-channel bank share stimulus; a reference model queues expected outputs.
module tb_led_pwm_bank;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic [1:0] cfg_chan;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_period;
  logic [7:0] cfg_duty;
  logic       sync_all;

  logic       ready0, err0, ready1, err1;
  logic [3:0] led0;
  logic [2:0] led1;

  always #5 clk = ~clk;

  led_pwm_bank #(.CHANNELS(4), .CNT_W(8), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(ready0), .cfg_chan(cfg_chan),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_err(err0),
    .sync_all(sync_all), .led(led0)
  );

  led_pwm_bank #(.CHANNELS(3), .CNT_W(8), .PRESCALE(P)) dut3 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(ready1), .cfg_chan(cfg_chan),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_err(err1),
    .sync_all(sync_all), .led(led1)
  );

  typedef struct {
    int led [2][4];
    int err [2];
    int ready;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: what each channel has been told and where it is in its period.
  int sh_mode [2][4], sh_per [2][4], sh_duty [2][4];
  int ac_mode [2][4], ac_per [2][4], ac_duty [2][4];
  int cnt [2][4], blink [2][4];
  int psc, m_ready;
  int nch, last;
  bit acc, tk;
  exp_t e;

  function automatic int led_value(input int mode, input int c, input int duty, input int b);
    case (mode)
      0: return 0;
      1: return 1;
      2: return b;
      default: return (c < duty) ? 1 : 0;
    endcase
  endfunction

  initial begin
    m_ready = 0;
    psc = 0;
    forever begin
      @(posedge clk);
      e.ready = rst ? 0 : 1;
      acc = cfg_valid && (m_ready == 1);
      tk = (psc == P - 1);
      for (int n = 0; n < 2; n++) begin
        nch = (n == 0) ? 4 : 3;
        e.err[n] = (!rst && acc && int'(cfg_chan) >= nch) ? 1 : 0;
        for (int c = 0; c < 4; c++) begin
          e.led[n][c] = 0;
          if (c >= nch) continue;
          if (rst) begin
            sh_mode[n][c] = 0; sh_per[n][c] = 0; sh_duty[n][c] = 0;
            ac_mode[n][c] = 0; ac_per[n][c] = 0; ac_duty[n][c] = 0;
            cnt[n][c] = 0; blink[n][c] = 0;
            continue;
          end
          e.led[n][c] = led_value(ac_mode[n][c], cnt[n][c], ac_duty[n][c], blink[n][c]);
          last = (ac_per[n][c] == 0) ? 0 : ac_per[n][c] - 1;
          if (sync_all || (tk && cnt[n][c] == last)) begin
            if (sh_mode[n][c] == 2 && ac_mode[n][c] != 2) blink[n][c] = 0;
            else if (!sync_all) blink[n][c] = 1 - blink[n][c];
            ac_mode[n][c] = sh_mode[n][c];
            ac_per[n][c] = sh_per[n][c];
            ac_duty[n][c] = sh_duty[n][c];
            cnt[n][c] = 0;
          end else if (tk) begin
            cnt[n][c] = cnt[n][c] + 1;
          end
          if (acc && int'(cfg_chan) == c) begin
            sh_mode[n][c] = int'(cfg_mode);
            sh_per[n][c] = int'(cfg_period);
            sh_duty[n][c] = int'(cfg_duty);
          end
        end
      end
      if (rst) psc = 0;
      else if (sync_all || tk) psc = 0;
      else psc = psc + 1;
      m_ready = rst ? 0 : 1;
      q.push_back(e);
    end
  end

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp_v);
    end
  endtask

  // Monitor: every cycle the banks present a new registered output set.
  initial begin
    exp_t x;
    int l0, l1;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        l0 = 0;
        l1 = 0;
        for (int c = 0; c < 4; c++) l0 |= x.led[0][c] << c;
        for (int c = 0; c < 3; c++) l1 |= x.led[1][c] << c;
        check("led4", int'(led0), l0);
        check("led3", int'(led1), l1);
        check("err4", int'(err0), x.err[0]);
        check("err3", int'(err1), x.err[1]);
        check("ready4", int'(ready0), x.ready);
        check("ready3", int'(ready1), x.ready);
      end
    end
  end

  task automatic write(input int ch, input int md, input int per, input int dt);
    cfg_valid = 1'b1;
    cfg_chan = 2'(ch);
    cfg_mode = 2'(md);
    cfg_period = 8'(per);
    cfg_duty = 8'(dt);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_sync();
    sync_all = 1'b1;
    @(negedge clk);
    sync_all = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_chan = 2'd0;
    cfg_mode = 2'd0;
    cfg_period = 8'd0;
    cfg_duty = 8'd0;
    sync_all = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(100);
    write(0, 1, 0, 0);
    write(1, 3, 4, 1);
    do_sync();
    idle(40);
    write(2, 2, 2, 0);
    do_sync();
    idle(40);
    idle(5);
    write(1, 3, 4, 3);
    idle(40);
    write(3, 3, 4, 9);
    write(3, 3, 4, 9);
    do_sync();
    idle(30);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(30);
    for (int i = 0; i < 3000; i++) begin
      cfg_valid = ($urandom_range(0, 99) < 35);
      cfg_chan = 2'($urandom_range(0, 3));
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_period = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      cfg_duty = 8'($urandom_range(0, 8));
      sync_all = ($urandom_range(0, 99) < 3);
      rst = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    sync_all = 1'b0;
    rst = 1'b0;
    idle(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
